// File: rtl/autocorr_lag_scheduler.sv
// Autocorrelation lag sequencer: walks lags MIN_LAG..MAX_LAG, drives sample-RAM
// addresses and the external MAC, and keeps the lag with the largest r[m].
module autocorr_lag_scheduler #(
    parameter int unsigned N       = 480,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned MIN_LAG = 20,
    parameter int unsigned MAX_LAG = 400,
    parameter int unsigned LAT     = 2,
    parameter int unsigned SUM_W   = 72
) (
    input  logic              Clk,
    input  logic              Reset_h,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              mac_clear,
    output logic              mac_en,
    input  logic [SUM_W-1:0]  mac_sum,
    output logic [ADDR_W-1:0] best_lag,
    output logic [SUM_W-1:0]  best_sum,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(LAT + 2);
    localparam logic [ADDR_W-1:0] MIN_L  = ADDR_W'(MIN_LAG);
    localparam logic [ADDR_W-1:0] MAX_L  = ADDR_W'(MAX_LAG);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(LAT);
    localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_COMPARE,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         m_q, m_d;
    logic [ADDR_W-1:0]         n_q, n_d;
    logic [CNT_W-1:0]          drain_q, drain_d;
    logic signed [SUM_W-1:0]   peak_q, peak_d;
    logic [ADDR_W-1:0]         peak_lag_q, peak_lag_d;
    logic [ADDR_W-1:0]         best_lag_q, best_lag_d;
    logic [SUM_W-1:0]          best_sum_q, best_sum_d;
    logic [ADDR_W-1:0]         addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]         addr_b_q, addr_b_d;
    logic                      busy_q, busy_d;
    logic                      clear_q, clear_d;
    logic                      done_q, done_d;
    logic [LAT-1:0]            en_sr_q, en_sr_d;
    logic                      issue_valid_c;
    logic [ADDR_W-1:0]         last_n_c;

    // Last n of the current lag keeps addr_b = n + m within the block
    assign last_n_c = LAST_A - m_q;

    always_comb begin
        state_d       = state_q;
        m_d           = m_q;
        n_d           = n_q;
        drain_d       = drain_q;
        peak_d        = peak_q;
        peak_lag_d    = peak_lag_q;
        best_lag_d    = best_lag_q;
        best_sum_d    = best_sum_q;
        addr_a_d      = addr_a_q;
        addr_b_d      = addr_b_q;
        issue_valid_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CLEAR;
                    m_d        = MIN_L;
                    peak_d     = SUM_MIN;
                    peak_lag_d = MIN_L;
                end
            end
            S_CLEAR: begin
                n_d     = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                issue_valid_c = 1'b1;
                n_d           = n_q + ADDR_W'(1);
                if (n_q == last_n_c) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_COMPARE;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            S_COMPARE: begin
                // Strict compare so ties keep the smaller lag
                if ($signed(mac_sum) > peak_q) begin
                    peak_d     = $signed(mac_sum);
                    peak_lag_d = m_q;
                end
                if (m_q == MAX_L) begin
                    state_d = S_DONE;
                end else begin
                    m_d     = m_q + ADDR_W'(1);
                    state_d = S_CLEAR;
                end
            end
            S_DONE: begin
                best_lag_d = peak_lag_q;
                best_sum_d = peak_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered addresses are loaded with the values for the coming ISSUE cycle
        if (state_d == S_ISSUE) begin
            addr_a_d = n_d;
            addr_b_d = n_d + m_d;
        end

        busy_d  = (state_d != S_IDLE);
        clear_d = (state_d == S_CLEAR);
        done_d  = (state_q == S_DONE);
        en_sr_d = LAT'({en_sr_q, issue_valid_c});
    end

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            n_q        <= '0;
            drain_q    <= '0;
            peak_q     <= '0;
            peak_lag_q <= '0;
            best_lag_q <= '0;
            best_sum_q <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            busy_q     <= 1'b0;
            clear_q    <= 1'b0;
            done_q     <= 1'b0;
            en_sr_q    <= '0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            n_q        <= n_d;
            drain_q    <= drain_d;
            peak_q     <= peak_d;
            peak_lag_q <= peak_lag_d;
            best_lag_q <= best_lag_d;
            best_sum_q <= best_sum_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            busy_q     <= busy_d;
            clear_q    <= clear_d;
            done_q     <= done_d;
            en_sr_q    <= en_sr_d;
        end
    end

    assign busy      = busy_q;
    assign addr_a    = addr_a_q;
    assign addr_b    = addr_b_q;
    assign mac_clear = clear_q;
    assign mac_en    = en_sr_q[LAT-1];
    assign best_lag  = best_lag_q;
    assign best_sum  = best_sum_q;
    assign done      = done_q;

endmodule

// File: tb/tb_autocorr_lag_scheduler.sv
// Directed bench for autocorr_lag_scheduler: a 16-sample instance and a
// full-block instance, each with a behavioural sample RAM and MAC attached.
module tb_autocorr_lag_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s, start_s, busy_s, mac_clear_s, mac_en_s, done_s;
    logic [8:0]  addr_a_s, addr_b_s, best_lag_s;
    logic [71:0] mac_sum_s, best_sum_s;
    logic        rst_d, start_d, busy_d, mac_clear_d, mac_en_d, done_d;
    logic [8:0]  addr_a_d, addr_b_d, best_lag_d;
    logic [71:0] mac_sum_d, best_sum_d;

    autocorr_lag_scheduler #(
        .N(16), .ADDR_W(9), .MIN_LAG(1), .MAX_LAG(8), .LAT(2), .SUM_W(72)
    ) dut_s (
        .Clk(clk), .Reset_h(rst_s), .start(start_s), .busy(busy_s),
        .addr_a(addr_a_s), .addr_b(addr_b_s), .mac_clear(mac_clear_s),
        .mac_en(mac_en_s), .mac_sum(mac_sum_s), .best_lag(best_lag_s),
        .best_sum(best_sum_s), .done(done_s)
    );

    autocorr_lag_scheduler #(
        .N(480), .ADDR_W(9), .MIN_LAG(20), .MAX_LAG(40), .LAT(2), .SUM_W(72)
    ) dut_d (
        .Clk(clk), .Reset_h(rst_d), .start(start_d), .busy(busy_d),
        .addr_a(addr_a_d), .addr_b(addr_b_d), .mac_clear(mac_clear_d),
        .mac_en(mac_en_d), .mac_sum(mac_sum_d), .best_lag(best_lag_d),
        .best_sum(best_sum_d), .done(done_d)
    );

    // Sample RAM (1-cycle read) + multiplier register + accumulator: LAT = 2
    logic signed [15:0] mem_s [0:511];
    logic signed [15:0] mem_d [0:511];
    logic signed [15:0] rda_s, rdb_s, rda_d, rdb_d;
    logic signed [31:0] prod_s, prod_d;
    logic [71:0]        acc_s = '0;
    logic [71:0]        acc_d = '0;

    always @(posedge clk) begin
        rda_s  <= mem_s[addr_a_s];
        rdb_s  <= mem_s[addr_b_s];
        prod_s <= rda_s * rdb_s;
        if (mac_clear_s) acc_s <= '0;
        else if (mac_en_s) acc_s <= acc_s + {{40{prod_s[31]}}, prod_s};
        rda_d  <= mem_d[addr_a_d];
        rdb_d  <= mem_d[addr_b_d];
        prod_d <= rda_d * rdb_d;
        if (mac_clear_d) acc_d <= '0;
        else if (mac_en_d) acc_d <= acc_d + {{40{prod_d[31]}}, prod_d};
    end
    assign mac_sum_s = acc_s;
    assign mac_sum_d = acc_d;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int done_cnt_s = 0;
    int done_cnt_d = 0;
    always @(negedge clk) begin
        if (done_s === 1'b1) done_cnt_s++;
        if (done_d === 1'b1) done_cnt_d++;
    end

    // Issue monitor for the small instance: mac_en at t pairs with addresses at t-2
    bit         mon_on = 1'b0;
    int         lag_cur = 0;
    int         en_cnt = 0;
    logic [8:0] a_d1, a_d2, b_d1, b_d2;
    always @(negedge clk) begin
        if (mon_on) begin
            if (mac_clear_s) begin
                if (lag_cur != 0) check_eq("mac_en_count", 72'(en_cnt), 72'(16 - lag_cur));
                lag_cur++;
                en_cnt = 0;
            end
            if (mac_en_s) begin
                check_eq("issue_addr_a", 72'(a_d2), 72'(en_cnt));
                check_eq("issue_lag", 72'(b_d2 - a_d2), 72'(lag_cur));
                en_cnt++;
            end
            if (done_s) begin
                check_eq("mac_en_count_last", 72'(en_cnt), 72'(16 - lag_cur));
                check_eq("lag_count", 72'(lag_cur), 72'(8));
            end
        end
        a_d2 = a_d1;
        a_d1 = addr_a_s;
        b_d2 = b_d1;
        b_d1 = addr_b_s;
    end

    task automatic run_block(input bit big, output int cycles);
        @(negedge clk);
        if (big) start_d = 1'b1;
        else     start_s = 1'b1;
        @(posedge clk);
        #1;
        start_d = 1'b0;
        start_s = 1'b0;
        cycles  = 0;
        while ((big ? done_d : done_s) !== 1'b1 && cycles < 20000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_eq(big ? "done_seen_d" : "done_seen_s", 72'(big ? done_d : done_s), 72'(1));
    endtask

    int cyc;

    initial begin
        rst_s = 1'b1; rst_d = 1'b1; start_s = 1'b0; start_d = 1'b0;
        for (int i = 0; i < 512; i++) begin
            mem_s[i] = '0;
            mem_d[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 72'(busy_s), 72'(0));
        check_eq("rst_addr_a", 72'(addr_a_s), 72'(0));
        check_eq("rst_addr_b", 72'(addr_b_s), 72'(0));
        check_eq("rst_mac_clear", 72'(mac_clear_s), 72'(0));
        check_eq("rst_mac_en", 72'(mac_en_s), 72'(0));
        check_eq("rst_done", 72'(done_s), 72'(0));
        check_eq("rst_best_lag", 72'(best_lag_s), 72'(0));
        check_eq("rst_best_sum", best_sum_s, 72'(0));
        check_eq("rst_busy_d", 72'(busy_d), 72'(0));
        check_eq("rst_done_d", 72'(done_d), 72'(0));
        @(negedge clk);
        rst_s = 1'b0; rst_d = 1'b0;

        // Spikes of 100 every 5 samples: r[5] = 3 * 10000
        for (int i = 0; i < 16; i += 5) mem_s[i] = 16'sd100;
        mon_on = 1'b1; lag_cur = 0; en_cnt = 0;
        run_block(1'b0, cyc);
        check_eq("spike_cycles", 72'(cyc), 72'(133));
        check_eq("spike_best_lag", 72'(best_lag_s), 72'(5));
        check_eq("spike_best_sum", best_sum_s, 72'(30000));
        check_eq("spike_busy_at_done", 72'(busy_s), 72'(0));
        mon_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("spike_done_once", 72'(done_cnt_s), 72'(1));
        check_eq("spike_done_pulse", 72'(done_s), 72'(0));

        // Reset in the middle of ISSUE
        @(negedge clk) start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_mac_en_active", 72'(mac_en_s), 72'(1));
        @(negedge clk) rst_s = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_busy", 72'(busy_s), 72'(0));
        check_eq("mid_rst_mac_en", 72'(mac_en_s), 72'(0));
        check_eq("mid_rst_best_lag", 72'(best_lag_s), 72'(0));
        @(negedge clk) rst_s = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check_eq("mid_rst_no_done", 72'(done_cnt_s), 72'(1));
        check_eq("mid_rst_idle", 72'(busy_s), 72'(0));
        check_eq("mid_rst_mac_en_idle", 72'(mac_en_s), 72'(0));

        // All-zero block: every lag ties at 0, earliest wins
        for (int i = 0; i < 16; i++) mem_s[i] = '0;
        run_block(1'b0, cyc);
        check_eq("zero_cycles", 72'(cyc), 72'(133));
        check_eq("zero_best_lag", 72'(best_lag_s), 72'(1));
        check_eq("zero_best_sum", best_sum_s, 72'(0));

        // +50/-50 alternating: r[m] = +-(16-m)*2500, best at lag 2
        for (int i = 0; i < 16; i++) mem_s[i] = (i % 2 == 0) ? 16'sd50 : -16'sd50;
        run_block(1'b0, cyc);
        check_eq("alt_best_lag", 72'(best_lag_s), 72'(2));
        check_eq("alt_best_sum", best_sum_s, 72'(35000));
        repeat (5) @(posedge clk);
        #1;
        check_eq("alt_hold_lag", 72'(best_lag_s), 72'(2));
        check_eq("alt_hold_sum", best_sum_s, 72'(35000));
        check_eq("alt_done_count", 72'(done_cnt_s), 72'(3));

        // Full block, 10 every 25 samples: r[25] = 19 * 100; extra start while busy
        for (int i = 0; i < 480; i += 25) mem_d[i] = 16'sd10;
        @(negedge clk) start_d = 1'b1;
        @(posedge clk);
        #1 start_d = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk) start_d = 1'b1;
        @(negedge clk) start_d = 1'b0;
        cyc = 0;
        while (done_d !== 1'b1 && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("busy_start_done_seen", 72'(done_d), 72'(1));
        check_eq("busy_start_best_lag", 72'(best_lag_d), 72'(25));
        check_eq("busy_start_best_sum", best_sum_d, 72'(1900));
        repeat (50) @(posedge clk);
        #1;
        check_eq("busy_start_ignored", 72'(done_cnt_d), 72'(1));
        check_eq("busy_start_idle", 72'(busy_d), 72'(0));

        run_block(1'b1, cyc);
        check_eq("repeat_cycles", 72'(cyc), 72'(9556));
        check_eq("repeat_best_lag", 72'(best_lag_d), 72'(25));
        check_eq("repeat_best_sum", best_sum_d, 72'(1900));
        repeat (3) @(posedge clk);
        #1;
        check_eq("repeat_done_count", 72'(done_cnt_d), 72'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/autocorr_lag_scheduler.md
Name: autocorr_lag_scheduler

Overview:
Sequencer for the pitch-detection autocorrelation datapath. Once a 480-sample block is captured, it drives the sample-buffer read addresses and the shared multiply-accumulate unit, evaluating r[m] = sum over n of x[n]*x[n+m] for every lag m in [MIN_LAG, MAX_LAG]. It tracks the lag with the largest r[m] and reports it to the pitch-conversion logic. Sample RAM, signed multiplier and accumulator are external; this block owns sequencing and peak selection only.

Parameters:
N, 480, samples per block
ADDR_W, 9, sample address width
MIN_LAG, 20, first lag evaluated (>=1)
MAX_LAG, 400, last lag evaluated (<=N-1, >=MIN_LAG)
LAT, 2, cycles from address issue to product valid at accumulator input
SUM_W, 72, accumulator width (signed)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset_h  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, new block ready; honoured only in IDLE
busy  out  1  high from the cycle after accepted start through DONE
addr_a  out  ADDR_W  sample RAM read address, port A (x[n])
addr_b  out  ADDR_W  sample RAM read address, port B (x[n+m])
mac_clear  out  1  zero the accumulator this cycle
mac_en  out  1  accumulate the product presented this cycle
mac_sum  in  SUM_W  signed accumulator output, registered
best_lag  out  ADDR_W  lag of maximum r[m], valid when done
best_sum  out  SUM_W  r[best_lag], signed
done  out  1  one-cycle pulse, results valid

Behaviour:
- Reset: state IDLE; busy, mac_clear, mac_en, done, addr_a, addr_b, best_lag, best_sum = 0; issue delay line flushed. Applies mid-operation, with mac_en low from the next cycle on.
- States: IDLE, CLEAR, ISSUE, DRAIN, COMPARE, DONE.
- IDLE: start=1 -> CLEAR; m<=MIN_LAG; internal peak <= most negative SUM_W value, peak lag <= MIN_LAG. start in any other state is ignored, not queued.
- CLEAR (1 cycle): mac_clear=1; n<=0; -> ISSUE.
- ISSUE: addr_a=n, addr_b=n+m, issue_valid=1; n++. Exactly N-m issues per lag (n = 0..N-1-m); after the last issue -> DRAIN. addr_b never exceeds N-1.
- mac_en = issue_valid delayed exactly LAT cycles through a shift register. No other source.
- DRAIN: LAT+1 cycles (pipeline empty plus accumulator register) -> COMPARE.
- COMPARE (1 cycle): signed strict compare. If mac_sum > peak, then peak<=mac_sum and peak lag<=m. Ties keep the earlier (smaller) lag. If m==MAX_LAG -> DONE, else m++ -> CLEAR.
- DONE (1 cycle): best_lag/best_sum <= peak values; done=1; -> IDLE. best_* hold until the next DONE or reset.
- Per-lag cost: 1 + (N-m) + (LAT+1) + 1 cycles. done occurs sum over m of that cost, plus 1, cycles after the edge sampling start.
- addr_a/addr_b hold their last value outside ISSUE. mac_clear is never high in the same cycle as mac_en.

Test Plan:
- Reset: hold Reset_h 2 cycles -> all outputs 0, busy 0. Pulse Reset_h mid-ISSUE -> IDLE next cycle, mac_en 0 from the following cycle, no done.
- Config N=16, MIN_LAG=1, MAX_LAG=8, LAT=2, x[n]=100 at n=0,5,10,15, else 0 -> best_lag=5, best_sum=30000, done exactly once.
- Same config, timing: done rises 133 cycles after the start edge. Per lag, count mac_en pulses = 16-m and check addr_b-addr_a = m on every issue.
- Same config, all-zero samples -> best_lag=1 (tie rule), best_sum=0.
- Same config, x alternating +50/-50 -> odd lags negative; best_lag=2, best_sum=35000.
- Default params, start pulsed again while busy -> ignored. Exactly one done; next start after done accepted and produces a repeat result.
